// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - EX->MEM->WB handshake, data SRAM response and forwarding bundle
interface lsu_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int PC_W   = 32
);
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic              es_mem_req;
    logic [2:0]        es_ld_op;
    logic              es_gr_we;
    logic [DEST_W-1:0] es_dest;
    logic [DATA_W-1:0] es_alu_result;
    logic [PC_W-1:0]   es_pc;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              flush;
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic              ms_gr_we;
    logic [DEST_W-1:0] ms_dest;
    logic [DATA_W-1:0] ms_final_result;
    logic [PC_W-1:0]   ms_pc;
    logic              ms_ale;
    logic              ms_fwd_valid;
    logic              ms_fwd_blocked;

    modport slave (
        input  es_to_ms_valid, es_mem_req, es_ld_op, es_gr_we, es_dest, es_alu_result, es_pc,
        input  data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_gr_we, ms_dest, ms_final_result, ms_pc,
        output ms_ale, ms_fwd_valid, ms_fwd_blocked
    );

    modport master (
        output es_to_ms_valid, es_mem_req, es_ld_op, es_gr_we, es_dest, es_alu_result, es_pc,
        output data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_gr_we, ms_dest, ms_final_result, ms_pc,
        input  ms_ale, ms_fwd_valid, ms_fwd_blocked
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - MEM stage waiting on split-transaction data SRAM, with load extraction
// Optional misaligned-load trap enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_mem_stage #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    lsu_mem_stage_if.slave    bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY, S_DROP} state_e;

    state_e            state_q, state_d, entry_state;
    logic              gr_we_q;
    logic [DEST_W-1:0] dest_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] rdata_q;
    logic [PC_W-1:0]   pc_q;
    logic [2:0]        ld_op_q;
    logic              accept;
    logic              misaligned;

    assign bus.ms_allowin = (state_q == S_IDLE) || (state_q == S_READY && bus.ws_allowin);
    // A flushing cycle never takes a new entry: whatever EX offers is being killed too.
    assign accept = bus.es_to_ms_valid && bus.ms_allowin && !bus.flush;

`ifdef LSU_ALIGN_CHECK_EN
    logic ale_q;

    always_comb begin
        misaligned = 1'b0;
        case (bus.es_ld_op)
            3'd3, 3'd4: misaligned = bus.es_alu_result[0];
            3'd5, 3'd6: misaligned = |bus.es_alu_result[1:0];
            3'd7:       misaligned = (DATA_W == 64) ? |bus.es_alu_result[2:0]
                                                    : |bus.es_alu_result[1:0];
            default:    misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)       ale_q <= 1'b0;
        else if (accept) ale_q <= misaligned;
    end

    assign bus.ms_ale = ale_q;
`else
    assign misaligned = 1'b0;
    assign bus.ms_ale = 1'b0;
`endif

    assign entry_state = (bus.es_mem_req && !misaligned) ? S_WAIT : S_READY;

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            case (state_q)
                S_WAIT, S_DROP: state_d = bus.data_sram_data_ok ? S_IDLE : S_DROP;
                default:        state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = entry_state;
                S_WAIT:  if (bus.data_sram_data_ok) state_d = S_READY;
                S_READY: if (bus.ws_allowin) state_d = accept ? entry_state : S_IDLE;
                S_DROP:  if (bus.data_sram_data_ok) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gr_we_q <= 1'b0;
            dest_q  <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            pc_q    <= '0;
            ld_op_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gr_we_q <= bus.es_gr_we && !misaligned;
                dest_q  <= bus.es_dest;
                alu_q   <= bus.es_alu_result;
                pc_q    <= bus.es_pc;
                ld_op_q <= bus.es_ld_op;
            end
            if (state_q == S_WAIT && bus.data_sram_data_ok)
                rdata_q <= bus.data_sram_rdata;
        end
    end

    // Lane select works off the hold buffer only, so WB never sees live SRAM data.
    logic [OFF_W-1:0]  off_b, off_h, off_w;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       word_sel;
    logic [DATA_W-1:0] result;

    assign off_b    = alu_q[OFF_W-1:0];
    assign off_h    = off_b & ~OFF_W'(1);
    assign off_w    = off_b & ~OFF_W'(3);
    assign byte_sel = 8'(rdata_q >> {off_b, 3'b000});
    assign half_sel = 16'(rdata_q >> {off_h, 3'b000});
    assign word_sel = 32'(rdata_q >> {off_w, 3'b000});

    always_comb begin
        result = alu_q;
        case (ld_op_q)
            3'd1: result = DATA_W'($signed(byte_sel));
            3'd2: result = DATA_W'(byte_sel);
            3'd3: result = DATA_W'($signed(half_sel));
            3'd4: result = DATA_W'(half_sel);
            3'd5: result = DATA_W'($signed(word_sel));
            3'd6: result = (DATA_W == 64) ? DATA_W'(word_sel) : DATA_W'($signed(word_sel));
            3'd7: result = (DATA_W == 64) ? rdata_q : DATA_W'($signed(word_sel));
            default: result = alu_q;
        endcase
    end

    assign bus.ms_to_ws_valid  = (state_q == S_READY);
    assign bus.ms_gr_we        = gr_we_q;
    assign bus.ms_dest         = dest_q;
    assign bus.ms_pc           = pc_q;
    assign bus.ms_final_result = result;
    assign bus.ms_fwd_valid    = (state_q == S_WAIT || state_q == S_READY) && gr_we_q;
    assign bus.ms_fwd_blocked  = (state_q == S_WAIT);
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - directed bench with a queue model for lsu_mem_stage at 32 and 64 bits
module tb_lsu_mem_stage;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALE_EN = 1'b1;
`else
    localparam bit ALE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_mem_stage_if #(.DATA_W(32), .DEST_W(5), .PC_W(32)) bus ();
    lsu_mem_stage_if #(.DATA_W(64), .DEST_W(5), .PC_W(32)) bus64 ();

    lsu_mem_stage #(.DATA_W(32), .DEST_W(5), .PC_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    lsu_mem_stage #(.DATA_W(64), .DEST_W(5), .PC_W(32)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        we;
        logic        ale;
        logic        chk_res;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic        chk_en = 1'b0;
    logic        exp_wait = 1'b0, exp_wait_we = 1'b0, exp_drop = 1'b0;
    int          cnt_blocked, cnt_alo, cnt_valid, cyc = 0;
    logic        retire;
    logic [2:0]  cur_op;
    logic [31:0] cur_addr, cur_pc;
    logic [4:0]  cur_dest;
    logic        cur_we, last_ale;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] rd);
        int off;
        logic [31:0] r;
        off = int'(addr[1:0]);
        case (op)
            3'd1, 3'd2: begin
                r = (rd >> (8 * off)) & 32'hFF;
                if (op == 3'd1 && r[7]) r = r | 32'hFFFF_FF00;
            end
            3'd3, 3'd4: begin
                r = (rd >> (8 * ((off / 2) * 2))) & 32'hFFFF;
                if (op == 3'd3 && r[15]) r = r | 32'hFFFF_0000;
            end
            3'd5, 3'd6, 3'd7: r = rd;
            default: r = addr;
        endcase
        return r;
    endfunction

    function automatic logic is_misal(input logic [2:0] op, input logic [31:0] addr);
        if (op == 3'd3 || op == 3'd4) return addr[0];
        if (op >= 3'd5) return addr[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // Model state advances 1 time unit after each DUT edge; outputs are judged at negedge.
    always begin
        @(negedge clk);
        retire = 1'b0;
        if (chk_en) begin
            chk("valid", bus.ms_to_ws_valid, q.size() != 0);
            chk("blocked", bus.ms_fwd_blocked, exp_wait);
            chk("allowin", bus.ms_allowin, !exp_wait && !exp_drop && (q.size() == 0 || bus.ws_allowin));
            chk("fwd_valid", bus.ms_fwd_valid, exp_wait ? exp_wait_we : (q.size() != 0 && q[0].we));
            if (bus.ms_to_ws_valid && q.size() != 0) begin
                chk("dest", bus.ms_dest, q[0].dest);
                chk("pc", bus.ms_pc, q[0].pc);
                chk("gr_we", bus.ms_gr_we, q[0].we);
                chk("ale", bus.ms_ale, q[0].ale);
                if (q[0].chk_res) chk("result", bus.ms_final_result, q[0].res);
            end
            if (bus.ms_fwd_blocked) cnt_blocked++;
            if (!bus.ms_allowin) cnt_alo++;
            if (bus.ms_to_ws_valid) cnt_valid++;
            retire = bus.ms_to_ws_valid && bus.ws_allowin;
        end
        @(posedge clk);
        #1;
        if (retire && q.size() != 0) void'(q.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        cnt_blocked = 0;
        cnt_alo = 0;
        cnt_valid = 0;
    endtask

    task automatic issue(input logic req, input logic [2:0] op, input logic [31:0] addr,
                         input logic [4:0] dest, input logic we, input logic [31:0] pc);
        int n;
        n = 0;
        bus.es_to_ms_valid = 1'b1;
        bus.es_mem_req     = req;
        bus.es_ld_op       = op;
        bus.es_alu_result  = addr;
        bus.es_dest        = dest;
        bus.es_gr_we       = we;
        bus.es_pc          = pc;
        @(negedge clk);
        while (!bus.ms_allowin && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: allowin stuck at 0, required 1");
        end
        tick();
        bus.es_to_ms_valid = 1'b0;
        bus.es_mem_req     = 1'b0;
        cur_op = op; cur_addr = addr; cur_dest = dest; cur_we = we; cur_pc = pc;
        last_ale = ALE_EN && is_misal(op, addr);
        if (last_ale) q.push_back('{32'h0, dest, pc, 1'b0, 1'b1, 1'b0});
        else if (req) begin
            exp_wait    = 1'b1;
            exp_wait_we = we;
        end else q.push_back('{addr, dest, pc, we, 1'b0, 1'b1});
    endtask

    task automatic respond(input logic [31:0] rdata, input logic [31:0] exp_res);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = rdata;
        tick();
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = $urandom;
        exp_wait = 1'b0;
        q.push_back('{exp_res, cur_dest, cur_pc, cur_we, 1'b0, 1'b1});
    endtask

    task automatic run64(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] rdata,
                         input logic [63:0] exp);
        bus64.es_to_ms_valid = 1'b1;
        bus64.es_mem_req     = 1'b1;
        bus64.es_ld_op       = op;
        bus64.es_alu_result  = addr;
        tick();
        bus64.es_to_ms_valid    = 1'b0;
        bus64.es_mem_req        = 1'b0;
        bus64.data_sram_data_ok = 1'b1;
        bus64.data_sram_rdata   = rdata;
        tick();
        bus64.data_sram_data_ok = 1'b0;
        bus64.data_sram_rdata   = '1;
        @(negedge clk);
        chk("r64_valid", bus64.ms_to_ws_valid, 1'b1);
        chk("r64_result", bus64.ms_final_result, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.es_to_ms_valid = 0; bus.es_mem_req = 0; bus.es_ld_op = 0; bus.es_gr_we = 0;
        bus.es_dest = 0; bus.es_alu_result = 0; bus.es_pc = 0; bus.data_sram_data_ok = 0;
        bus.data_sram_rdata = 0; bus.flush = 0; bus.ws_allowin = 1;
        bus64.es_to_ms_valid = 0; bus64.es_mem_req = 0; bus64.es_ld_op = 0; bus64.es_gr_we = 1;
        bus64.es_dest = 1; bus64.es_alu_result = 0; bus64.es_pc = 0; bus64.data_sram_data_ok = 0;
        bus64.data_sram_rdata = 0; bus64.flush = 0; bus64.ws_allowin = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_valid", bus.ms_to_ws_valid, 1'b0);
        chk("rst_allowin", bus.ms_allowin, 1'b1);
        chk("rst_blocked", bus.ms_fwd_blocked, 1'b0);
        chk("rst_result", bus.ms_final_result, 32'h0);
        chk("rst_gr_we", bus.ms_gr_we, 1'b0);
        chk("rst_ale", bus.ms_ale, 1'b0);
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // lb at offset 3, response two cycles after accept
        clr_cnt();
        issue(1'b1, 3'd1, 32'h0000_1003, 5'd3, 1'b1, 32'h100);
        tick();
        respond(32'h80FF_1234, 32'hFFFF_FF80);
        chk("lb_blocked_cycles", cnt_blocked, 2);
        tick();
        chk("lb_valid_cycles", cnt_valid, 1);

        // lhu held while WB stalls for three cycles
        bus.ws_allowin = 1'b0;
        issue(1'b1, 3'd4, 32'h0000_2002, 5'd7, 1'b1, 32'h104);
        respond(32'h8001_7FFF, 32'h0000_8001);
        clr_cnt();
        tick(); tick(); tick();
        chk("hold_valid_cycles", cnt_valid, 3);
        chk("hold_allowin_low", cnt_alo, 3);
        bus.ws_allowin = 1'b1;
        tick();

        // flush in WAIT, killed response four cycles later; flush in DROP is inert
        issue(1'b1, 3'd5, 32'h0000_3000, 5'd9, 1'b1, 32'h108);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        exp_wait = 1'b0;
        exp_drop = 1'b1;
        clr_cnt();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hDEAD_BEEF;
        tick();
        bus.data_sram_data_ok = 1'b0;
        exp_drop = 1'b0;
        chk("drop_allowin_low", cnt_alo, 4);
        chk("drop_valid_cycles", cnt_valid, 0);
        tick();

        // back-to-back ALU entries, one per cycle
        clr_cnt();
        begin
            int t0;
            t0 = cyc;
            for (int i = 0; i < 4; i++)
                issue(1'b0, 3'd0, 32'h1000_0000 + 32'(i) * 32'h111, 5'(10 + i), i != 2, 32'h200 + 32'(4 * i));
            chk("b2b_cycles", cyc - t0, 4);
        end
        tick();
        chk("b2b_valid_cycles", cnt_valid, 4);

        // literal lane checks, then a sweep of every op and offset against the model
        issue(1'b1, 3'd3, 32'h0000_4000, 5'd4, 1'b1, 32'h300);
        respond(32'h8A7B_C6F5, 32'hFFFF_C6F5);
        issue(1'b1, 3'd2, 32'h0000_4002, 5'd5, 1'b1, 32'h304);
        respond(32'h8A7B_C6F5, 32'h0000_007B);
        for (int op = 1; op < 8; op++)
            for (int off = 0; off < 4; off++) begin
                issue(1'b1, 3'(op), 32'h0000_5000 + 32'(off), 5'(op), 1'b1, 32'(op * 16 + off));
                if (!last_ale) respond(32'h8A7B_C6F5, extract(3'(op), 32'h0000_5000 + 32'(off), 32'h8A7B_C6F5));
            end
        tick();

        // flush with same-cycle data_ok returns to IDLE; flush in READY drops the entry
        issue(1'b1, 3'd5, 32'h0000_6000, 5'd11, 1'b1, 32'h400);
        bus.flush = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        exp_wait = 1'b0;
        tick();
        bus.ws_allowin = 1'b0;
        issue(1'b0, 3'd0, 32'h0000_0042, 5'd12, 1'b1, 32'h404);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        q.delete();
        bus.ws_allowin = 1'b1;
        tick();

        // stray data_ok in IDLE is ignored
        bus.data_sram_data_ok = 1'b1;
        tick();
        bus.data_sram_data_ok = 1'b0;
        tick();

        // misaligned ld.w: trap with the check compiled in, truncated lane otherwise
        issue(1'b1, 3'd5, 32'h0000_7002, 5'd13, 1'b1, 32'h500);
        if (!last_ale) respond(32'h1234_5678, 32'h1234_5678);
        tick();
        tick();

        // 64-bit datapath
        run64(3'd7, 64'h0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
        run64(3'd6, 64'h4, 64'h8000_0000_0000_0001, 64'h0000_0000_8000_0000);
        run64(3'd5, 64'h4, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000);
        run64(3'd1, 64'h7, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FF80);
        run64(3'd4, 64'h6, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_8000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Parametrised memory-access pipeline stage for the in-order CPU, sitting between EX and WB. Unlike the previous fixed-latency MEM stage, it waits on a split-transaction data SRAM (request accepted in EX, response `data_ok` in MEM). It holds an early-returned response while WB stalls and discards in-flight responses after a pipeline flush. Load extraction supports byte, half, word, and, when 64-bit, word-unsigned and doubleword, with sign or zero extension.

## Interface
- `DATA_W`, 32, datapath and SRAM data width; 32 or 64 only.
- `DEST_W`, 5, register index width.
- `PC_W`, 32, PC width.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `es_to_ms_valid`  in  1  EX entry valid.
- `ms_allowin`  out  1  MEM can accept an entry this cycle.
- `es_mem_req`  in  1  entry is a load whose SRAM request was accepted (`addr_ok`) in EX.
- `es_ld_op`  in  3  0 none, 1 b, 2 bu, 3 h, 4 hu, 5 w, 6 wu, 7 d.
- `es_gr_we`  in  1  register write enable.
- `es_dest`  in  DEST_W  destination register.
- `es_alu_result`  in  DATA_W  ALU result or load address.
- `es_pc`  in  PC_W  instruction PC.
- `data_sram_data_ok`  in  1  read response valid.
- `data_sram_rdata`  in  DATA_W  read response data.
- `flush`  in  1  exception or ertn from WB; kills the MEM entry.
- `ws_allowin`  in  1  WB can accept.
- `ms_to_ws_valid`  out  1  entry ready for WB.
- `ms_gr_we`, `ms_dest`, `ms_final_result`, `ms_pc`  out  1/DEST_W/DATA_W/PC_W  to WB.
- `ms_ale`  out  1  misaligned load (macro only; else tied 0).
- `ms_fwd_valid`  out  1  `ms_valid && ms_gr_we`.
- `ms_fwd_blocked`  out  1  valid load whose data is not yet available; ID stalls on a match.

## Operation
- Entry states:
  - IDLE: no entry.
  - WAIT: load awaiting `data_ok`.
  - READY: result available.
  - DROP: no valid entry, one killed response still outstanding.
- On accept (`es_to_ms_valid && ms_allowin`):
  - `es_mem_req=1` goes to WAIT.
  - Otherwise goes to READY.
- WAIT with `data_ok`: latch `rdata` into the hold buffer and go to READY. The result is derived from the buffer, never from live `rdata`.
- READY with `ws_allowin`: the entry leaves. If a new entry is accepted in the same cycle, the state follows that entry; otherwise IDLE.
- Lane selection:
  - Byte offset is `addr[log2(DATA_W/8)-1:0]`.
  - b/bu pick byte[offset].
  - h/hu pick halfword[offset>>1].
  - w/wu pick word[offset>>2].
  - d takes the whole word.
  - Signed ops replicate the selected MSB to DATA_W. Unsigned ops zero-fill.
  - At DATA_W=32, ops 6 and 7 behave as 5.
- `ld_op=0`: `ms_final_result = alu_result`.
- `flush`, highest priority:
  - The entry is invalidated.
  - From WAIT without a same-cycle `data_ok`, go to DROP.
  - Otherwise go to IDLE.
- DROP:
  - `ms_allowin=0`.
  - The next `data_ok` is discarded and the state goes to IDLE.
  - `flush` in DROP has no further effect.
- `ms_allowin = (state==IDLE) || (state==READY && ws_allowin)`.
- `ms_to_ws_valid = (state==READY)`.
- At most one outstanding response exists. EX must not issue a new request while MEM is in WAIT or DROP.

## Timing
- Reset: state IDLE, hold buffer 0, all outputs 0. `ms_allowin` is 1 in the first cycle after reset.
- A reset mid-WAIT does not create DROP. The SRAM side is reset by the same signal.
- `data_ok` is honoured in any cycle in WAIT, including the first cycle after accept. Minimum load latency in MEM is 1 cycle; non-loads take 0 extra cycles.
- `data_ok` in IDLE or READY is a protocol error and is ignored.
- `ms_fwd_blocked` is 1 exactly in WAIT. It goes to 0 in the cycle after `data_ok`.
- All outputs are driven from registers plus the extraction mux. There is no combinational path from `data_sram_rdata` to outputs.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - A misaligned load sets `ms_ale=1` and the entry enters READY directly.
  - Misaligned means h/hu with `addr[0]`, w/wu with `addr[1:0]!=0`, or d with `addr[2:0]!=0`.
  - EX must not have issued the request in this case; `es_mem_req` is ignored.
  - `ms_gr_we` is forced to 0.
- Undefined: `ms_ale=0`. Misaligned addresses use the truncated lane select.

## Test plan
- DATA_W=32, lb at addr 0x...03, `data_ok` with rdata 0x80FF_1234 after 2 cycles -> `ms_fwd_blocked` 1 for 2 cycles, then result 0xFFFF_FF80.
- lhu at addr 0x...02, rdata 0x8001_7FFF, `data_ok` the cycle after accept, `ws_allowin=0` for 3 cycles -> result held at 0x0000_8001, `ms_to_ws_valid` held at 1, `ms_allowin=0` for those 3 cycles.
- `flush` in WAIT, `data_ok` 4 cycles later -> DROP, `ms_allowin=0` for 4 cycles, response discarded, IDLE with `ms_allowin=1` the cycle after.
- Back-to-back ALU ops with `ws_allowin=1` -> one entry retires per cycle and `ms_final_result` equals the ALU result.
- DATA_W=64: ld.d rdata 0x8000_0000_0000_0001 -> result unchanged; ld.wu at offset 4 -> 0x0000_0000_8000_0000.
- Macro on: ld.w at addr 0x...02 -> `ms_ale=1`, `ms_gr_we=0`, no wait for `data_ok`.
